// File: rtl/hps_reset_sequencer.sv
// HPS reset-request sequencer: latches cold/warm/debug request edges and issues one
// prioritised low pulse at a time to the HPS. Define HPS_RST_SEQ_REQ_SYNC_EN to synchronise req_in.
module hps_reset_sequencer #(
    parameter int COLD_PULSE  = 6,
    parameter int WARM_PULSE  = 2,
    parameter int DEBUG_PULSE = 32,
    parameter int HOLDOFF     = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req_in,
    input  logic       h2f_reset_n,
    output logic       cold_req_n,
    output logic       warm_req_n,
    output logic       debug_req_n,
    output logic       busy,
    output logic [2:0] pending,
    output logic [1:0] grant
);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        HOLD,
        WAIT_HPS
    } state_t;

    localparam logic [7:0] COLD_LD  = 8'(COLD_PULSE - 1);
    localparam logic [7:0] WARM_LD  = 8'(WARM_PULSE - 1);
    localparam logic [7:0] DEBUG_LD = 8'(DEBUG_PULSE - 1);
    localparam logic [7:0] HOLD_LD  = 8'(HOLDOFF - 1);

    localparam logic [1:0] GRANT_COLD  = 2'd1;
    localparam logic [1:0] GRANT_WARM  = 2'd2;
    localparam logic [1:0] GRANT_DEBUG = 2'd3;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] grant_q, grant_d;
    logic [2:0] pending_q, pending_d;
    logic [2:0] clr;
    logic [2:0] req_s;
    logic [2:0] req_prev_q;
    logic [2:0] edge_q;
    logic       h2f_meta_q, h2f_sync_q;
    logic       cold_n_q, warm_n_q, debug_n_q, busy_q;
    logic       cold_n_d, warm_n_d, debug_n_d, busy_d;

`ifdef HPS_RST_SEQ_REQ_SYNC_EN
    logic [2:0] req_meta_q, req_sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_meta_q <= '0;
            req_sync_q <= '0;
        end else begin
            req_meta_q <= req_in;
            req_sync_q <= req_meta_q;
        end
    end

    assign req_s = req_sync_q;
`else
    assign req_s = req_in;
`endif

    // Previous value resets to 0 so a request held through reset release reads as an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_prev_q <= '0;
            edge_q     <= '0;
            h2f_meta_q <= 1'b0;
            h2f_sync_q <= 1'b0;
        end else begin
            req_prev_q <= req_s;
            edge_q     <= req_s & ~req_prev_q;
            h2f_meta_q <= h2f_reset_n;
            h2f_sync_q <= h2f_meta_q;
        end
    end

    // A new edge wins over a same-cycle grant clear.
    assign pending_d = (pending_q & ~clr) | edge_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        clr     = '0;
        case (state_q)
            IDLE: begin
                if (pending_q != 3'b000) begin
                    state_d = PULSE;
                    if (pending_q[0]) begin
                        grant_d = GRANT_COLD;
                        clr     = 3'b111;
                        cnt_d   = COLD_LD;
                    end else if (pending_q[1]) begin
                        grant_d = GRANT_WARM;
                        clr     = 3'b010;
                        cnt_d   = WARM_LD;
                    end else begin
                        grant_d = GRANT_DEBUG;
                        clr     = 3'b100;
                        cnt_d   = DEBUG_LD;
                    end
                end
            end
            PULSE: begin
                if (cnt_q == 8'd0) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            HOLD: begin
                if (cnt_q == 8'd0) begin
                    state_d = h2f_sync_q ? IDLE : WAIT_HPS;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            WAIT_HPS: begin
                if (h2f_sync_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from next-state so they line up with the state register.
    always_comb begin
        cold_n_d  = !(state_d == PULSE && grant_d == GRANT_COLD);
        warm_n_d  = !(state_d == PULSE && grant_d == GRANT_WARM);
        debug_n_d = !(state_d == PULSE && grant_d == GRANT_DEBUG);
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            grant_q   <= '0;
            pending_q <= '0;
            cold_n_q  <= 1'b1;
            warm_n_q  <= 1'b1;
            debug_n_q <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            pending_q <= pending_d;
            cold_n_q  <= cold_n_d;
            warm_n_q  <= warm_n_d;
            debug_n_q <= debug_n_d;
            busy_q    <= busy_d;
        end
    end

    assign cold_req_n  = cold_n_q;
    assign warm_req_n  = warm_n_q;
    assign debug_req_n = debug_n_q;
    assign busy        = busy_q;
    assign pending     = pending_q;
    assign grant       = grant_q;

endmodule

// File: tb/tb_hps_reset_sequencer.sv
// Scoreboard bench for hps_reset_sequencer: expected pulses (type, start cycle, width)
// are queued as stimulus is driven and matched against pulses recorded by a monitor.
module tb_hps_reset_sequencer;

`ifdef HPS_RST_SEQ_REQ_SYNC_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    typedef struct {
        int kind;
        int start;
        int width;
    } pulse_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] req_in = 3'b000;
    logic       h2f_reset_n = 1'b1;
    logic       cold_req_n, warm_req_n, debug_req_n, busy;
    logic [2:0] pending;
    logic [1:0] grant;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    pulse_t exp_q[$];
    pulse_t obs_q[$];
    int     run_len[3];
    int     run_start[3];

    hps_reset_sequencer #(
        .COLD_PULSE (6),
        .WARM_PULSE (2),
        .DEBUG_PULSE(32),
        .HOLDOFF    (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_in     (req_in),
        .h2f_reset_n(h2f_reset_n),
        .cold_req_n (cold_req_n),
        .warm_req_n (warm_req_n),
        .debug_req_n(debug_req_n),
        .busy       (busy),
        .pending    (pending),
        .grant      (grant)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: records every completed low pulse on the three request outputs.
    always @(negedge clk) begin
        logic [2:0] lv;
        lv = {debug_req_n, warm_req_n, cold_req_n};
        for (int i = 0; i < 3; i++) begin
            if (lv[i] === 1'b0) begin
                if (run_len[i] == 0) run_start[i] = cyc;
                run_len[i]++;
            end else if (run_len[i] > 0) begin
                obs_q.push_back('{kind: i + 1, start: run_start[i], width: run_len[i]});
                run_len[i] = 0;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_in = 3'b000;
        repeat (3) tick();
        tests++;
        if ({debug_req_n, warm_req_n, cold_req_n} !== 3'b111) begin
            fails++;
            $display("FAIL reset_req_n: got %b expected 111", {debug_req_n, warm_req_n, cold_req_n});
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
        tests++;
        if (pending !== 3'b000) begin
            fails++;
            $display("FAIL reset_pending: got %b expected 000", pending);
        end
        tests++;
        if (grant !== 2'd0) begin
            fails++;
            $display("FAIL reset_grant: got %0d expected 0", grant);
        end
        reset = 1'b0;
        repeat (3) tick();
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_single_cold();
        int c0, bcnt;
        pulse_t e, o;
        c0 = cyc;
        req_in = 3'b001;
        exp_q.push_back('{kind: 1, start: c0 + LAT, width: 6});
        tick();
        req_in = 3'b000;
        bcnt = 0;
        repeat (40) begin
            if (busy === 1'b1) bcnt++;
            tick();
        end
        tests++;
        if (bcnt !== 22) begin
            fails++;
            $display("FAIL cold_busy_len: got %0d expected 22", bcnt);
        end
        tests++;
        if (grant !== 2'd1) begin
            fails++;
            $display("FAIL cold_grant: got %0d expected 1", grant);
        end
        tests++;
        if (pending !== 3'b000 || busy !== 1'b0) begin
            fails++;
            $display("FAIL cold_idle: got pending=%b busy=%b expected 000/0", pending, busy);
        end
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL cold_count: got %0d pulses expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests++;
            if (o.kind !== e.kind || o.start !== e.start || o.width !== e.width) begin
                fails++;
                $display("FAIL cold_pulse: got type=%0d start=%0d width=%0d expected type=%0d start=%0d width=%0d",
                         o.kind, o.start, o.width, e.kind, e.start, e.width);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_cold_supersedes();
        int c0;
        pulse_t e, o;
        c0 = cyc;
        req_in = 3'b011;
        exp_q.push_back('{kind: 1, start: c0 + LAT, width: 6});
        tick();
        req_in = 3'b000;
        repeat (LAT - 2) tick();
        tests++;
        if (pending !== 3'b011) begin
            fails++;
            $display("FAIL both_pending_set: got %b expected 011", pending);
        end
        tick();
        tests++;
        if (pending !== 3'b000) begin
            fails++;
            $display("FAIL both_pending_clear: got %b expected 000", pending);
        end
        repeat (30) tick();
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL both_count: got %0d pulses expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests++;
            if (o.kind !== e.kind || o.start !== e.start || o.width !== e.width) begin
                fails++;
                $display("FAIL both_pulse: got type=%0d start=%0d width=%0d expected type=%0d start=%0d width=%0d",
                         o.kind, o.start, o.width, e.kind, e.start, e.width);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_warm_during_debug();
        int c0;
        pulse_t e, o;
        c0 = cyc;
        req_in = 3'b100;
        exp_q.push_back('{kind: 3, start: c0 + LAT, width: 32});
        exp_q.push_back('{kind: 2, start: c0 + LAT + 32 + 16 + 1, width: 2});
        tick();
        req_in = 3'b000;
        repeat (8) tick();
        req_in = 3'b010;
        tick();
        req_in = 3'b000;
        repeat (4) tick();
        tests++;
        if (pending !== 3'b010 || debug_req_n !== 1'b0) begin
            fails++;
            $display("FAIL dbg_warm_pending: got pending=%b debug_req_n=%b expected 010/0", pending, debug_req_n);
        end
        repeat (60) tick();
        tests++;
        if (grant !== 2'd2 || busy !== 1'b0 || pending !== 3'b000) begin
            fails++;
            $display("FAIL dbg_warm_end: got grant=%0d busy=%b pending=%b expected 2/0/000", grant, busy, pending);
        end
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL dbg_warm_count: got %0d pulses expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests++;
            if (o.kind !== e.kind || o.start !== e.start || o.width !== e.width) begin
                fails++;
                $display("FAIL dbg_warm_pulse: got type=%0d start=%0d width=%0d expected type=%0d start=%0d width=%0d",
                         o.kind, o.start, o.width, e.kind, e.start, e.width);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_wait_hps();
        int c0, ch;
        pulse_t e, o;
        c0 = cyc;
        req_in = 3'b001;
        exp_q.push_back('{kind: 1, start: c0 + LAT, width: 6});
        tick();
        req_in = 3'b000;
        repeat (3) tick();
        h2f_reset_n = 1'b0;
        tick();
        req_in = 3'b010;
        tick();
        req_in = 3'b000;
        repeat (34) tick();
        tests++;
        if (busy !== 1'b1 || warm_req_n !== 1'b1 || pending !== 3'b010) begin
            fails++;
            $display("FAIL wait_hold: got busy=%b warm_req_n=%b pending=%b expected 1/1/010",
                     busy, warm_req_n, pending);
        end
        ch = cyc;
        h2f_reset_n = 1'b1;
        exp_q.push_back('{kind: 2, start: ch + 4, width: 2});
        repeat (30) tick();
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL wait_count: got %0d pulses expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests++;
            if (o.kind !== e.kind || o.start !== e.start || o.width !== e.width) begin
                fails++;
                $display("FAIL wait_pulse: got type=%0d start=%0d width=%0d expected type=%0d start=%0d width=%0d",
                         o.kind, o.start, o.width, e.kind, e.start, e.width);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset_mid_pulse();
        int c0, cr;
        pulse_t e, o;
        c0 = cyc;
        req_in = 3'b001;
        exp_q.push_back('{kind: 1, start: c0 + LAT, width: 3});
        tick();
        req_in = 3'b010;
        tick();
        req_in = 3'b000;
        repeat (LAT) tick();
        tests++;
        if (cold_req_n !== 1'b0 || pending !== 3'b010) begin
            fails++;
            $display("FAIL midrst_before: got cold_req_n=%b pending=%b expected 0/010", cold_req_n, pending);
        end
        #2 reset = 1'b1;
        #1;
        tests++;
        if (cold_req_n !== 1'b1 || pending !== 3'b000 || busy !== 1'b0 || grant !== 2'd0) begin
            fails++;
            $display("FAIL midrst_async: got cold_req_n=%b pending=%b busy=%b grant=%0d expected 1/000/0/0",
                     cold_req_n, pending, busy, grant);
        end
        repeat (2) tick();
        reset = 1'b0;
        repeat (40) tick();
        // Held-high request across a second reset release must yield one debug pulse.
        reset = 1'b1;
        req_in = 3'b100;
        tick();
        cr = cyc;
        reset = 1'b0;
        exp_q.push_back('{kind: 3, start: cr + LAT, width: 32});
        repeat (10) tick();
        req_in = 3'b000;
        repeat (60) tick();
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL midrst_count: got %0d pulses expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests++;
            if (o.kind !== e.kind || o.start !== e.start || o.width !== e.width) begin
                fails++;
                $display("FAIL midrst_pulse: got type=%0d start=%0d width=%0d expected type=%0d start=%0d width=%0d",
                         o.kind, o.start, o.width, e.kind, e.start, e.width);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_back_to_back();
        int c0;
        pulse_t e, o;
        c0 = cyc;
        req_in = 3'b001;
        exp_q.push_back('{kind: 1, start: c0 + LAT, width: 6});
        exp_q.push_back('{kind: 1, start: c0 + LAT + 6 + 16 + 1, width: 6});
        tick();
        req_in = 3'b000;
        tick();
        req_in = 3'b001;
        tick();
        req_in = 3'b000;
        repeat (60) tick();
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL b2b_count: got %0d pulses expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests++;
            if (o.kind !== e.kind || o.start !== e.start || o.width !== e.width) begin
                fails++;
                $display("FAIL b2b_pulse: got type=%0d start=%0d width=%0d expected type=%0d start=%0d width=%0d",
                         o.kind, o.start, o.width, e.kind, e.start, e.width);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            run_len[i] = 0;
            run_start[i] = 0;
        end
        #1 reset = 1'b1;
        test_reset();
        test_single_cold();
        test_cold_supersedes();
        test_warm_during_debug();
        test_wait_hps();
        test_reset_mid_pulse();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hps_reset_sequencer.md
HPS_RESET_SEQUENCER -- requirements
Module: hps_reset_sequencer

Interface
REQ-001 SHALL have parameter COLD_PULSE, default 6: cold-request low-pulse width in clk cycles, range 1..255.
REQ-002 SHALL have parameter WARM_PULSE, default 2: warm-request low-pulse width in clk cycles, range 1..255.
REQ-003 SHALL have parameter DEBUG_PULSE, default 32: debug-request low-pulse width in clk cycles, range 1..255.
REQ-004 SHALL have parameter HOLDOFF, default 16: quiet cycles after each pulse, range 1..255.
REQ-005 SHALL have port clk, input, 1: single clock (50 MHz system clock).
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port req_in, input, 3: level reset requests; bit0 cold, bit1 warm, bit2 debug.
REQ-008 SHALL have port h2f_reset_n, input, 1: HPS-to-FPGA reset status, asynchronous to clk.
REQ-009 SHALL have ports cold_req_n, warm_req_n and debug_req_n, each output, 1: active-low requests to the HPS.
REQ-010 SHALL have port busy, output, 1: high whenever the FSM is not in IDLE.
REQ-011 SHALL have port pending, output, 3: latched, not-yet-granted requests, with the same bit order as req_in.
REQ-012 SHALL have port grant, output, 2: last granted type; 0 none, 1 cold, 2 warm, 3 debug.

Function
REQ-013 SHALL detect a rising edge per req_in bit against a registered previous value.
- A request held high through reset release SHALL count as one edge.
REQ-014 SHALL set the matching pending bit on each detected edge.
- Edges arriving in any state SHALL be latched, never dropped.
REQ-015 SHALL give set priority over clear when an edge and a grant-clear hit the same pending bit in the same cycle.
REQ-016 SHALL implement FSM states IDLE, PULSE, HOLD, WAIT_HPS.
REQ-017 In IDLE with pending nonzero, the FSM SHALL:
- grant the highest-priority type (cold > warm > debug);
- clear that type's pending bit;
- load the counter with that type's pulse width minus 1;
- update grant;
- go to PULSE.
REQ-018 A cold grant SHALL also clear the warm and debug pending bits (cold supersedes).
REQ-019 In PULSE, only the granted *_req_n SHALL be low, for exactly the configured pulse width in cycles.
- On the terminal count, the FSM SHALL load HOLDOFF-1 and go to HOLD.
REQ-020 In HOLD, all *_req_n SHALL be high.
- On the terminal count, the FSM SHALL go to WAIT_HPS if the synchronized h2f_reset_n is 0, otherwise to IDLE.
REQ-021 In WAIT_HPS, the FSM SHALL remain until the synchronized h2f_reset_n is 1, then go to IDLE.
REQ-022 h2f_reset_n SHALL always pass through a 2-flop synchronizer before use.
REQ-023 All outputs SHALL be registered.
- With the synchronizer off, *_req_n SHALL go low at the 2nd rising edge after the edge where the req_in rise is first sampled.
REQ-024 Counter SHALL be 8 bits with no wrap.
- The state exits at count 0; the counter never decrements below 0.
REQ-025 Back-to-back same-type edges SHALL produce two separate pulses, separated by at least HOLDOFF cycles.

Reset
REQ-026 While reset is high, the block SHALL hold cold_req_n=1, warm_req_n=1, debug_req_n=1, busy=0, pending=0, grant=0, state IDLE, counter=0, and edge and sync registers=0.
REQ-027 Reset asserted mid-PULSE SHALL release the active *_req_n to 1 asynchronously and discard all pending requests.

Configuration
REQ-028 With macro HPS_RST_SEQ_REQ_SYNC_EN defined, req_in SHALL pass through a 2-flop synchronizer before edge detection, adding exactly 2 cycles of latency.
- Without the macro, req_in SHALL be used directly and SHALL be synchronous to clk.

Verification
REQ-029 Single-cycle req_in=001 after reset (defaults, macro off) -> cold_req_n low for exactly 6 cycles starting 2 cycles later; busy high for 6+16 cycles; grant=1.
REQ-030 req_in=011 rising in the same cycle -> one 6-cycle cold pulse; pending returns to 000; warm_req_n never low.
REQ-031 req_in bit1 rising during the 32-cycle debug pulse -> debug completes, then 16 HOLD cycles, then a 2-cycle warm pulse; pending[1]=1 in between.
REQ-032 h2f_reset_n=0 at HOLD end with warm pending -> busy stays 1 and no pulse until h2f_reset_n=1; the warm pulse follows 3-4 cycles later.
REQ-033 reset asserted at cycle 3 of a cold pulse -> cold_req_n=1 immediately, pending=000; after release, no pulse without a new edge unless req_in is held high.
REQ-034 HPS_RST_SEQ_REQ_SYNC_EN defined, single req_in=100 -> debug_req_n low 4 cycles after the sample edge, for 32 cycles.
